multi_player_hp_ctrl: RTL
=========================

// Module: multi_player_hp_ctrl
// PURPOSE
//  Parametrised health/game-over controller for the tile-dodge game family.
//  Tracks HP for NUM_PLAYERS avatars on the 2 Hz game tick.
//  Applies collision damage in shift or decrement mode, with a post-hit invulnerability window and bonus healing.
//  Drives per-player alive flags and a global lose flag to the pixel renderer and top-level.
// PARAMETERS
//  NUM_PLAYERS  2  number of independent players (>=1)
//  HP_BITS      5  width of each HP register (>=2)
//  MODE         0  0 = thermometer (hit: hp>>1, heal: (hp<<1)|1); 1 = binary (hit: hp-1, heal: hp+1)
//  IFRAMES      2  ticks of invulnerability after a damaging hit (0 = none, max 15)
// PORTS
//  clk_2hz  in   1                    game tick clock
//  rst      in   1                    reset, asynchronous, active-high
//  hit      in   NUM_PLAYERS          per-player collision level, sampled each tick
//  heal     in   NUM_PLAYERS          per-player bonus-match level, sampled each tick
//  revive   in   1                    synchronous global restart request
//  hp       out  NUM_PLAYERS*HP_BITS  packed HP; player i at [i*HP_BITS +: HP_BITS]
//  alive    out  NUM_PLAYERS          1 = player state != DEAD
//  invuln   out  NUM_PLAYERS          1 = player in INVULN state
//  dmg_evt  out  NUM_PLAYERS          1-tick pulse on the tick a hit reduced HP
//  lose     out  1                    1 = global state OVER
// BEHAVIOUR
//  - All outputs registered; inputs sampled at posedge clk_2hz; effect visible after that same edge (latency 1 tick).
//  - Reset values: hp = FULL for every player (all ones, both modes); alive = all 1; invuln = 0; dmg_evt = 0; lose = 0.
//    Reset is honoured mid-tick, mid-invulnerability and in OVER.
//  - Per-player FSM: ALIVE, INVULN, DEAD; 4-bit iframe counter per player.
//  - Per-tick priority, applied per player:
//    revive > DEAD-hold > heal > hit.
//  - revive=1: every player -> ALIVE, hp = FULL, counters = 0, dmg_evt = 0, lose = 0, global -> RUN.
//    Any hit/heal on that tick is ignored.
//  - DEAD: hp held at 0; hit and heal ignored; exits only by revive or rst.
//  - heal=1 (ALIVE or INVULN): hp increases, saturating at FULL.
//    Mode 0: hp = (hp<<1)|1. Mode 1: hp = hp+1.
//    State and counter unchanged. A hit on the same tick is discarded (no dmg_evt).
//  - hit=1, heal=0, ALIVE: hp decreases.
//    Mode 0: hp = hp>>1. Mode 1: hp = hp-1, floor 0.
//    dmg_evt = 1 for this tick.
//    If the new hp == 0: -> DEAD.
//    Else if IFRAMES > 0: -> INVULN, counter = IFRAMES.
//    Else: stay ALIVE.
//  - INVULN: hit is ignored, no dmg_evt.
//    Counter decrements each tick; when it is 1, the next state is ALIVE.
//    Hit is re-sampled on the first ALIVE tick, so a held hit damages every IFRAMES+1 ticks.
//  - hit held continuously with IFRAMES=0 damages every tick (single-player legacy behaviour).
//  - Global FSM: RUN, OVER.
//    RUN -> OVER on the same edge the last living player enters DEAD.
//    With NUM_PLAYERS=1 this is the first death.
//    OVER -> RUN only by revive or rst. lose = (state == OVER).
//  - In OVER all per-player state is frozen; hit and heal are ignored.
//  - HP arithmetic is HP_BITS wide with no overflow wrap. Mode 1 saturates both ends explicitly.
//    FULL = {HP_BITS{1'b1}} in both modes.
//  - dmg_evt is never asserted on a revive, rst or OVER tick.
// TESTING
//  1. rst pulse -> hp = 5'b11111 per player, alive = 2'b11, lose = 0.
//     Drop rst while clk_2hz is low -> no state change until the next edge.
//  2. MODE=0, IFRAMES=2, hit[0] held 6 ticks -> p0 hp 11111 -> 01111 (dmg_evt) -> hold -> hold -> 00111 (dmg_evt) -> hold -> hold.
//  3. MODE=1, HP_BITS=2, IFRAMES=0, hit[0] held -> p0 hp 3,2,1,0; alive[0] = 0 at the tick hp=0; lose stays 0 while p1 alive.
//  4. Then hit[1] held until p1 hp=0 -> lose = 1 on the same edge as alive[1] = 0.
//     Further hit/heal -> no change. revive -> hp = 11/11, alive = 11, lose = 0 after 1 tick.
//  5. hit[0] = heal[0] = 1 at hp = 00111 (MODE=0) -> hp = 01111, dmg_evt[0] = 0, state ALIVE.
//  6. MODE=1, hp = FULL, heal held 3 ticks -> hp stays FULL (saturation).
//     Assert rst mid-INVULN -> invuln = 0 immediately, asynchronously.

Source files
------------

// File: rtl/multi_player_hp_ctrl.sv
// -----------------------------------------------------------------------------
// multi_player_hp_ctrl
//   Health / game-over controller for the tile-dodge game family. Keeps one HP
//   register and one ALIVE/INVULN/DEAD state machine per player, all advanced
//   on the 2 Hz game tick. A global RUN/OVER machine raises lose once every
//   player is dead.
//
// Ports
//   clk_2hz  in   game tick clock
//   rst      in   asynchronous, active-high reset
//   hit      in   [NUM_PLAYERS]      per-player collision level
//   heal     in   [NUM_PLAYERS]      per-player bonus-match level
//   revive   in   synchronous global restart request
//   hp       out  [NUM_PLAYERS*HP_BITS] packed HP, player i at [i*HP_BITS +: HP_BITS]
//   alive    out  [NUM_PLAYERS]      player not DEAD
//   invuln   out  [NUM_PLAYERS]      player in INVULN
//   dmg_evt  out  [NUM_PLAYERS]      one-tick pulse when a hit lowered HP
//   lose     out  global state is OVER
// -----------------------------------------------------------------------------
module multi_player_hp_ctrl #(
    parameter int NUM_PLAYERS = 2,
    parameter int HP_BITS     = 5,
    parameter int MODE        = 0,
    parameter int IFRAMES     = 2
) (
    input  logic                           clk_2hz,
    input  logic                           rst,
    input  logic [NUM_PLAYERS-1:0]         hit,
    input  logic [NUM_PLAYERS-1:0]         heal,
    input  logic                           revive,
    output logic [NUM_PLAYERS*HP_BITS-1:0] hp,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic [NUM_PLAYERS-1:0]         invuln,
    output logic [NUM_PLAYERS-1:0]         dmg_evt,
    output logic                           lose
);

    typedef enum logic [1:0] {P_ALIVE, P_INVULN, P_DEAD} pstate_t;
    typedef enum logic       {G_RUN, G_OVER}             gstate_t;

    localparam logic [HP_BITS-1:0] FULL = '1;
    localparam logic [3:0]         IFR  = 4'(IFRAMES);

    // Heal: computed one bit wider so any carry out of the top saturates to FULL.
    function automatic logic [HP_BITS-1:0] hp_heal(input logic [HP_BITS-1:0] h);
        logic [HP_BITS:0] w;
        if (MODE == 0) w = {h, 1'b1};
        else           w = {1'b0, h} + (HP_BITS+1)'(1);
        return w[HP_BITS] ? FULL : w[HP_BITS-1:0];
    endfunction

    // Hit: thermometer halves, binary decrements with a floor at zero.
    function automatic logic [HP_BITS-1:0] hp_hit(input logic [HP_BITS-1:0] h);
        if (MODE == 0)         return h >> 1;
        else if (h == '0)      return '0;
        else                   return h - HP_BITS'(1);
    endfunction

    pstate_t            ps_q  [NUM_PLAYERS];
    pstate_t            ps_d  [NUM_PLAYERS];
    logic [3:0]         cnt_q [NUM_PLAYERS];
    logic [3:0]         cnt_d [NUM_PLAYERS];
    logic [HP_BITS-1:0] hp_d  [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] dmg_d;
    gstate_t            gs_q, gs_d;
    logic               all_dead;

    always_comb begin
        all_dead = 1'b1;
        dmg_d    = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) begin
            logic [HP_BITS-1:0] cur, nh;
            cur      = hp[i*HP_BITS +: HP_BITS];
            nh       = '0;
            ps_d[i]  = ps_q[i];
            cnt_d[i] = cnt_q[i];
            hp_d[i]  = cur;
            if (revive) begin
                ps_d[i]  = P_ALIVE;
                cnt_d[i] = '0;
                hp_d[i]  = FULL;
            end else if (gs_q == G_OVER || ps_q[i] == P_DEAD) begin
                // frozen: game over or player already dead
            end else begin
                // The invulnerability window runs on time alone; heal does not touch it.
                if (ps_q[i] == P_INVULN) begin
                    if (cnt_q[i] <= 4'd1) begin
                        ps_d[i]  = P_ALIVE;
                        cnt_d[i] = '0;
                    end else begin
                        cnt_d[i] = cnt_q[i] - 4'd1;
                    end
                end
                if (heal[i]) begin
                    hp_d[i] = hp_heal(cur);
                end else if (hit[i] && ps_q[i] == P_ALIVE) begin
                    nh       = hp_hit(cur);
                    hp_d[i]  = nh;
                    dmg_d[i] = 1'b1;
                    if (nh == '0) begin
                        ps_d[i]  = P_DEAD;
                        cnt_d[i] = '0;
                    end else if (IFR != 4'd0) begin
                        ps_d[i]  = P_INVULN;
                        cnt_d[i] = IFR;
                    end
                end
            end
            if (ps_d[i] != P_DEAD) all_dead = 1'b0;
        end

        // OVER is entered on the same edge the last living player dies.
        if (revive)                          gs_d = G_RUN;
        else if (gs_q == G_OVER || all_dead) gs_d = G_OVER;
        else                                 gs_d = G_RUN;
    end

    always_ff @(posedge clk_2hz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                ps_q[i]                  <= P_ALIVE;
                cnt_q[i]                 <= '0;
                hp[i*HP_BITS +: HP_BITS] <= FULL;
            end
            gs_q    <= G_RUN;
            alive   <= '1;
            invuln  <= '0;
            dmg_evt <= '0;
            lose    <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_PLAYERS; i++) begin
                ps_q[i]                  <= ps_d[i];
                cnt_q[i]                 <= cnt_d[i];
                hp[i*HP_BITS +: HP_BITS] <= hp_d[i];
                alive[i]                 <= (ps_d[i] != P_DEAD);
                invuln[i]                <= (ps_d[i] == P_INVULN);
            end
            gs_q    <= gs_d;
            dmg_evt <= dmg_d;
            lose    <= (gs_d == G_OVER);
        end
    end

endmodule
